// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: shared types, constants and BCD helpers for the alarm clock
// Contents: ring_state_t, TIME_MIDNIGHT, bcd_time_valid(), to_12h()
package alarm_clock_pkg;

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} ring_state_t;

    localparam logic [15:0] TIME_MIDNIGHT = 16'h0000;

    // Digit bounds first, so the packed-hour compare below is a numeric compare
    function automatic logic bcd_time_valid(input logic [15:0] t);
        return t[15:12] <= 4'd2 && t[11:8] <= 4'd9 && t[7:4] <= 4'd5 &&
               t[3:0] <= 4'd9 && t[15:8] <= 8'h23;
    endfunction

    // Returns {pm, HHMM} with the hour folded into 01..12
    function automatic logic [16:0] to_12h(input logic [15:0] t);
        logic [7:0] hb;
        logic [7:0] r;
        hb = 8'(t[15:12]) * 8'd10 + 8'(t[11:8]);
        r  = hb - 8'd12;
        if (hb == 8'd0)
            return {1'b0, 8'h12, t[7:0]};
        if (hb <= 8'd12)
            return {hb == 8'd12, t};
        return {1'b1, (r >= 8'd10) ? 4'd1 : 4'd0,
                (r >= 8'd10) ? 4'(r - 8'd10) : r[3:0], t[7:0]};
    endfunction

endpackage

// File: rtl/alarm_clock_core_bcd_time_counter.sv
// bcd_time_counter: HH:MM BCD register with validated load and minute increment
// Ports: clk256, reset (async, high), load/load_val (ignored if invalid), inc, q
module bcd_time_counter
    import alarm_clock_pkg::*;
(
    input  logic        clk256,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        inc,
    output logic [15:0] q
);

    logic [15:0] nxt;

    always_comb
        nxt = (q[3:0] != 4'd9)    ? q + 16'd1 :
              (q[7:4] != 4'd5)    ? {q[15:8], q[7:4] + 4'd1, 4'd0} :
              (q[15:8] == 8'h23)  ? TIME_MIDNIGHT :
              (q[11:8] != 4'd9)   ? {q[15:12], q[11:8] + 4'd1, 8'h00} :
                                    {q[15:12] + 4'd1, 12'h000};

    // A load strobe, even an invalid one, suppresses the increment that cycle
    always_ff @(posedge clk256 or posedge reset)
        if (reset)
            q <= TIME_MIDNIGHT;
        else if (load) begin
            if (bcd_time_valid(load_val))
                q <= load_val;
        end else if (inc)
            q <= nxt;

endmodule

// File: rtl/alarm_clock_core.sv
// alarm_clock_core: time counter, N alarms, snooze/timeout ringer and 12/24h display
// Ports: clk256, reset (async, high), one_minute, load_new_time/time_in,
//        load_alarm/alarm_sel/alarm_in, alarm_enable, snooze, alarm_off,
//        show_alarm, mode_12h -> current_time, display_out, pm, alarm_ring, ring_index
module alarm_clock_core
    import alarm_clock_pkg::*;
#(
    parameter int N_ALARMS         = 4,
    parameter int SNOOZE_MIN       = 9,
    parameter int RING_TIMEOUT_MIN = 10,
    parameter int AW               = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk256,
    input  logic                reset,
    input  logic                one_minute,
    input  logic                load_new_time,
    input  logic [15:0]         time_in,
    input  logic                load_alarm,
    input  logic [AW-1:0]       alarm_sel,
    input  logic [15:0]         alarm_in,
    input  logic [N_ALARMS-1:0] alarm_enable,
    input  logic                snooze,
    input  logic                alarm_off,
    input  logic                show_alarm,
    input  logic                mode_12h,
    output logic [15:0]         current_time,
    output logic [15:0]         display_out,
    output logic                pm,
    output logic                alarm_ring,
    output logic [AW-1:0]       ring_index
);

    logic [15:0] alarms [N_ALARMS];
    logic        tick_d, hit, sel_ok;
    logic [AW-1:0] win, idx_n;
    logic [3:0]  ring_cnt, snz_cnt, rc_n, sc_n;
    logic [15:0] src;
    logic [16:0] conv;
    ring_state_t state, state_n;

    bcd_time_counter u_time (
        .clk256   (clk256),
        .reset    (reset),
        .load     (load_new_time),
        .load_val (time_in),
        .inc      (one_minute),
        .q        (current_time)
    );

    assign sel_ok = int'(alarm_sel) < N_ALARMS;

    always_ff @(posedge clk256 or posedge reset)
        if (reset) begin
            for (int i = 0; i < N_ALARMS; i++)
                alarms[i] <= TIME_MIDNIGHT;
        end else if (load_alarm && sel_ok && bcd_time_valid(alarm_in))
            alarms[alarm_sel] <= alarm_in;

    // Match only after a real increment, never after a time load
    always_ff @(posedge clk256 or posedge reset)
        if (reset)
            tick_d <= 1'b0;
        else
            tick_d <= one_minute && !load_new_time;

    // Descending scan so the lowest matching index is the last one written
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--)
            if (alarm_enable[i] && alarms[i] == current_time) begin
                hit = 1'b1;
                win = AW'(i);
            end
    end

    always_ff @(posedge clk256 or posedge reset)
        if (reset) begin
            state      <= IDLE;
            ring_index <= '0;
            ring_cnt   <= '0;
            snz_cnt    <= '0;
        end else begin
            state      <= state_n;
            ring_index <= idx_n;
            ring_cnt   <= rc_n;
            snz_cnt    <= sc_n;
        end

    always_comb begin
        state_n = state;
        idx_n   = ring_index;
        rc_n    = ring_cnt;
        sc_n    = snz_cnt;
        case (state)
            IDLE:
                if (tick_d && hit) begin
                    state_n = RINGING;
                    idx_n   = win;
                    rc_n    = '0;
                end
            RINGING:
                if (alarm_off || !alarm_enable[ring_index])
                    state_n = IDLE;
                else if (snooze) begin
                    state_n = SNOOZED;
                    sc_n    = 4'(SNOOZE_MIN);
                end else if (tick_d) begin
                    rc_n    = ring_cnt + 4'd1;
                    state_n = (rc_n == 4'(RING_TIMEOUT_MIN)) ? IDLE : RINGING;
                end
            SNOOZED:
                if (alarm_off || !alarm_enable[ring_index])
                    state_n = IDLE;
                else if (tick_d && hit) begin
                    state_n = RINGING;
                    idx_n   = win;
                    rc_n    = '0;
                end else if (tick_d) begin
                    sc_n    = snz_cnt - 4'd1;
                    rc_n    = '0;
                    state_n = (sc_n == 4'd0) ? RINGING : SNOOZED;
                end
            default:
                state_n = IDLE;
        endcase
    end

    assign alarm_ring = state == RINGING;

    always_comb begin
        src  = show_alarm ? (sel_ok ? alarms[alarm_sel] : TIME_MIDNIGHT) : current_time;
        conv = to_12h(src);
    end

    always_ff @(posedge clk256 or posedge reset)
        if (reset) begin
            display_out <= TIME_MIDNIGHT;
            pm          <= 1'b0;
        end else begin
            display_out <= mode_12h ? conv[15:0] : src;
            pm          <= mode_12h && conv[16];
        end

endmodule
